// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: single-outstanding imem requests feeding a 2-entry {pc, inst} FIFO to decode.
// Optional bubble counter output enabled by defining FETCH_BUBBLE_CNT_EN.
module fetch_stage (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stallD,
    input  logic                 InstBranch,
    input  logic [11:0]          PC_branch,
    fetch_stage_if.master        imem,
    output logic [15:0]          i_inst,
    output logic [11:0]          pcD,
    output logic                 validD
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [15:0]          bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [11:0] drop_addr_q, drop_addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [11:0] fifo_pc_q   [2];
    logic [15:0] fifo_inst_q [2];
    logic        push;
    logic        pop;
    logic [1:0]  count_after_pop;

    assign validD          = (count_q != 2'd0);
    assign pop             = validD & ~stallD & ~InstBranch;
    assign count_after_pop = count_q - {1'b0, pop};
    assign i_inst          = validD ? fifo_inst_q[rd_ptr_q] : 16'h0000;
    assign pcD             = validD ? fifo_pc_q[rd_ptr_q]   : 12'h000;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drop_addr_d    = drop_addr_q;
        push           = 1'b0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (InstBranch) begin
                    pc_d    = PC_branch;
                    state_d = ST_REQ;
                end else if (count_after_pop < 2'd2) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                imem.imem_req = 1'b1;
                if (InstBranch) begin
                    pc_d = PC_branch;
                    // Unacked request must complete at its old address first.
                    if (!imem.imem_ack) begin
                        state_d     = ST_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem.imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + 12'd1;
                    if (count_after_pop == 2'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drop_addr_q;
                if (InstBranch) begin
                    pc_d = PC_branch;
                end
                if (imem.imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d  = count_after_pop + {1'b0, push};
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        if (InstBranch) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= 12'h000;
            drop_addr_q <= 12'h000;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // FIFO payload needs no reset: it is only visible while count_q is non-zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            localparam logic ENTRY_IDX = (gi == 1);
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == ENTRY_IDX)) begin
                    fifo_pc_q[gi]   <= pc_q;
                    fifo_inst_q[gi] <= imem.imem_data;
                end
            end
        end
    endgenerate

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= 16'h0000;
        end else if (!validD && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising clk edge.
REQ-004 stallD  input  1  decode cannot accept the presented instruction this cycle.
REQ-005 InstBranch  input  1  taken branch resolved in decode; redirect fetch.
REQ-006 PC_branch  input  12  branch target; valid when InstBranch=1.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  12  word address of the request; held stable while imem_req=1 and imem_ack=0.
REQ-009 imem_ack  input  1  read data valid on imem_data this cycle; completes the request.
REQ-010 imem_data  input  16  instruction word returned by memory.
REQ-011 i_inst  output  16  instruction to decode (opcode [15:12], src1 [11:8], src2 [7:4], dest [3:0]).
REQ-012 pcD  output  12  PC of i_inst.
REQ-013 validD  output  1  i_inst/pcD hold a real instruction.

Function
REQ-014 Fetch PC pc_f SHALL be 12 bits and increment by 1 per accepted response, wrapping 12'hFFF -> 12'h000.
REQ-015 The block SHALL contain a 2-entry FIFO of {pc, inst}; validD = FIFO not empty; i_inst/pcD = head entry, else 16'h0000/12'h000.
REQ-016 The head SHALL pop on a rising edge where validD=1 and stallD=0 and InstBranch=0.
REQ-017 FSM states SHALL be IDLE, REQ and DROP; imem_req=1 in REQ and DROP, 0 in IDLE.
REQ-018 IDLE -> REQ when (entries - pop) < 2; imem_addr=pc_f in REQ.
REQ-019 REQ with imem_ack=1 and InstBranch=0: push {pc_f, imem_data}, pc_f+1; go IDLE if FIFO then holds 2 entries, else stay REQ.
REQ-020 At most one request SHALL be outstanding; imem_ack may be asserted in the first cycle of imem_req.
REQ-021 InstBranch=1 (any state): FIFO flushed, no push, pc_f <= PC_branch; validD=0 on the next cycle.
REQ-022 Branch in REQ with imem_ack=0: go DROP; imem_req and imem_addr SHALL stay at the old address until ack.
REQ-023 DROP: response data discarded on ack, then go REQ with the redirected pc_f; a further branch in DROP updates pc_f and keeps DROP.
REQ-024 Branch in REQ with imem_ack=1 in the same cycle: data discarded, go REQ at PC_branch next cycle.
REQ-025 Simultaneous push and pop SHALL keep the entry count unchanged and preserve order.
REQ-026 Minimum latency: request issued at edge N with ack in cycle N -> validD=1 from edge N+1.

Reset
REQ-027 reset SHALL force pc_f=0, FIFO empty, state IDLE, imem_req=0, validD=0, i_inst=16'h0000, pcD=12'h000.
REQ-028 reset asserted mid-request SHALL abandon it; a stale imem_ack after reset SHALL be ignored in IDLE.

Configuration
REQ-029 With FETCH_BUBBLE_CNT_EN defined, output bubble_cnt[15:0] SHALL count cycles with validD=0 outside reset, saturating at 16'hFFFF, cleared by reset.
REQ-030 Without FETCH_BUBBLE_CNT_EN, port bubble_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then ack in every request cycle, stallD=0 -> pcD sequence 0,1,2,3 on consecutive cycles, validD=1 from the 2nd cycle after reset release.
REQ-032 stallD=1 held for 5 cycles -> FIFO fills to 2, imem_req=0, i_inst/pcD frozen; on release, two pops on back-to-back cycles.
REQ-033 Branch to 12'h100 while a request to 12'h005 is waiting 3 cycles for ack -> data from 005 dropped, next imem_addr=12'h100, first pcD after the branch=12'h100.
REQ-034 pc_f=12'hFFF with immediate acks -> pcD FFF then 000.
REQ-035 Branch with imem_ack in the same cycle, target 12'h040 -> no push, next request at 12'h040.
REQ-036 With FETCH_BUBBLE_CNT_EN: 3 empty cycles after reset -> bubble_cnt=3; forced to 16'hFFFF, it stays 16'hFFFF.
